// File: rtl/burst_pkg.sv
// Shared types and helpers for the burst memory engine: FSM states, burst
// mode encodings, address sequencing and command legality.
package burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  // Computed at 32 bits; callers truncate to their address width, which
  // gives the modulo-depth wrap of INCR bursts for free.
  function automatic logic [31:0] burst_next_addr(
    input logic [31:0] start,
    input logic [31:0] length,
    input logic        mode,
    input logic [31:0] beat
  );
    logic [31:0] mask;
    logic [31:0] sum;
    mask = length - 32'd1;
    sum  = start + beat;
    if (mode == MODE_WRAP) begin
      return (start & ~mask) | (sum & mask);
    end
    return sum;
  endfunction

  function automatic logic burst_cmd_legal(
    input logic        wr,
    input logic        rd,
    input logic [31:0] length,
    input logic        mode,
    input int          max_burst
  );
    logic len_ok;
    logic pow2;
    len_ok = (length != 32'd0) && (length <= 32'(max_burst));
    pow2   = ((length & (length - 32'd1)) == 32'd0);
    return (wr ^ rd) && len_ok && ((mode == MODE_INCR) || pow2);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Combinational beat address generator: start address, length and mode in,
// word address of beat n out.
module burst_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              mode,
  input  logic [LEN_W-1:0]  beat,
  output logic [ADDR_W-1:0] addr
);
  import burst_pkg::*;

  assign addr = ADDR_W'(burst_next_addr(32'(start_addr), 32'(length), mode, 32'(beat)));

endmodule

// File: rtl/burst_mem_engine.sv
// Burst read/write engine around an internal word-addressed register memory,
// with valid/ready beat channels and command rejection.
//
//   state | meaning
//   IDLE  | waiting for io_start; validates the command
//   WRITE | accepting write beats while io_wready is high
//   READ  | presenting registered read beats on io_rdata/io_rvalid
//   RESP  | single cycle: io_done pulse, then back to IDLE
module burst_mem_engine #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [ADDR_W-1:0] io_address,
  input  logic [LEN_W-1:0]  io_length,
  input  logic              io_mode,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_wvalid,
  output logic              io_wready,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_rvalid,
  input  logic              io_rready,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_error
);
  import burst_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] beat_addr;
  logic              cmd_ok;
  logic              rd_hs;

  burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .start_addr (start_q),
    .length     (len_q),
    .mode       (mode_q),
    .beat       (beat_q),
    .addr       (beat_addr)
  );

  assign cmd_ok = burst_cmd_legal(io_wr, io_rd, 32'(io_length), io_mode, MAX_BURST);
  assign rd_hs  = rvalid_q & io_rready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    start_d  = start_q;
    mode_d   = mode_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    error_d  = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (io_start) begin
          if (!cmd_ok) begin
            error_d = 1'b1;
          end else begin
            start_d = io_address;
            len_d   = io_length;
            mode_d  = io_mode;
            beat_d  = '0;
            if (io_wr) begin
              state_d = WRITE;
            end else begin
              // Beat 0 is always the start address, so prefetch it now to
              // have io_rvalid up in the first READ cycle.
              state_d  = READ;
              rdata_d  = mem_q[io_address];
              rvalid_d = 1'b1;
              beat_d   = LEN_W'(1);
            end
          end
        end
      end

      WRITE: begin
        if (io_wvalid) begin
          mem_we = 1'b1;
          if (beat_q == len_q - LEN_W'(1)) begin
            state_d = RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end

      READ: begin
        // beat_q counts beats already fetched into rdata_q.
        if (rd_hs) begin
          if (beat_q == len_q) begin
            state_d  = RESP;
            rvalid_d = 1'b0;
            beat_d   = '0;
          end else begin
            rdata_d = mem_q[beat_addr];
            beat_d  = beat_q + LEN_W'(1);
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      len_q    <= '0;
      start_q  <= '0;
      mode_q   <= MODE_INCR;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      start_q  <= start_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      error_q  <= error_d;
    end
  end

  // Contents survive reset; a beat presented on the reset edge is dropped.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem_q[beat_addr] <= io_wdata;
    end
  end

  assign io_wready = (state_q == WRITE);
  assign io_busy   = (state_q == WRITE) || (state_q == READ);
  assign io_done   = (state_q == RESP);
  assign io_rdata  = rdata_q;
  assign io_rvalid = rvalid_q;
  assign io_error  = error_q;

endmodule

// File: doc/burst_mem_engine.md
Name: burst_mem_engine

Overview:
- Parametrised burst read/write engine with an internal word-addressed memory.
- Accepts one command per transaction (address, beat count, direction, burst mode), then moves data beats over valid/ready channels with backpressure on both write and read.
- Successor to the fixed 4-bit/32-bit burst pair. Adds:
  - parametrised widths and depth;
  - WRAP burst mode;
  - write/read handshakes;
  - command error detection.

Parameters:
- DATA_W, 32, width of data beats.
- ADDR_W, 4, word address width; memory depth = 2**ADDR_W.
- LEN_W, 4, width of the beat-count field.
- MAX_BURST, 8, largest legal beat count (must be ≤ 2**LEN_W-1).

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- io_start  in  1  command strobe.
- io_wr  in  1  command is a write burst.
- io_rd  in  1  command is a read burst.
- io_address  in  ADDR_W  start word address.
- io_length  in  LEN_W  number of beats.
- io_mode  in  1  0 = INCR, 1 = WRAP.
- io_wdata  in  DATA_W  write beat data.
- io_wvalid  in  1  write beat valid.
- io_wready  out  1  engine accepts a write beat.
- io_rdata  out  DATA_W  read beat data.
- io_rvalid  out  1  read beat valid.
- io_rready  in  1  consumer accepts a read beat.
- io_busy  out  1  transaction in progress.
- io_done  out  1  one-cycle pulse: burst completed.
- io_error  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state←IDLE, beat counter←0.
  - io_wready, io_rvalid, io_busy, io_done, io_error = 0; io_rdata = 0.
  - Memory contents are not reset.
  - Reset mid-burst aborts it: remaining beats are lost; beats already written remain in memory.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - A command is sampled when io_start=1.
  - It is legal iff exactly one of io_wr/io_rd is set, 1 ≤ io_length ≤ MAX_BURST, and (io_mode=0 or io_length is a power of two).
  - Legal write → WRITE. Legal read → READ. io_busy=1 from the next cycle.
  - Illegal command: io_error pulses for 1 cycle on the next cycle; state stays IDLE; memory is untouched.
  - io_start in any state other than IDLE is ignored.
- Address generation (ADDR_W arithmetic):
  - INCR: addr(n) = (start + n) mod 2**ADDR_W, wrapping at the top of memory.
  - WRAP: base = start & ~(length-1); addr(n) = base | ((start + n) & (length-1)).
- WRITE:
  - io_wready=1 throughout WRITE.
  - Each cycle with io_wvalid=1 stores io_wdata at addr(n), n++.
  - io_wvalid=0 stalls with no state change.
  - After beat length-1 is accepted → RESP.
- READ:
  - Memory read is registered.
  - The first io_rvalid rises 1 cycle after command acceptance.
  - io_rdata/io_rvalid hold stable while io_rvalid=1 and io_rready=0.
  - On io_rvalid & io_rready, the next beat is presented the following cycle, giving 1 beat/cycle under continuous io_rready.
  - After the last beat handshakes → RESP; io_rvalid=0.
- RESP:
  - Lasts 1 cycle: io_done=1, io_busy=0, next state IDLE.
  - A new command is accepted the cycle after RESP.
- Widths: the beat counter is LEN_W bits. io_length = 0 is always an error, never an infinite burst.

Decomposition:
- Shared package (burst_pkg):
  - state enum {IDLE, WRITE, READ, RESP};
  - mode constants MODE_INCR=0, MODE_WRAP=1;
  - the address-next function used for INCR/WRAP.
- One natural sub-module, burst_addr_gen:
  - inputs: start, length, mode, beat index;
  - output: addr(n).
  - It is combinational and is unit-tested separately.
- The memory stays inline as a register array.

Test Plan:
- INCR write, then read:
  - Stimulus: write addr=6, len=4, mode=0, beats A,B,C,D on consecutive cycles; then read addr=6, len=4 with io_rready=1.
  - Required: io_rdata = A,B,C,D on 4 consecutive cycles; io_done pulses once per burst.
- Top-of-memory INCR wrap:
  - Stimulus: write addr=14, len=4, data 1,2,3,4 (ADDR_W=4).
  - Required: words 14,15,0,1 hold 1,2,3,4; reading back addr=0, len=2 returns 3,4.
- WRAP burst:
  - Stimulus: write addr=5, len=4, mode=1, data 10,11,12,13.
  - Required: words 5,6,7,4 = 10,11,12,13; read addr=4, len=4, INCR returns 13,10,11,12.
- Backpressure:
  - Stimulus: read len=4; io_rready toggles 1,0,0,1,...; io_wvalid gaps of 2 cycles during a write.
  - Required: no beat lost or duplicated; io_rdata is stable while stalled.
- Illegal commands:
  - Stimulus: wr=rd=1; len=0; len=9; WRAP with len=3.
  - Required: each gives io_error=1 for exactly 1 cycle, io_busy stays 0, memory is unchanged.
- Reset mid-burst:
  - Stimulus: write len=4, drive reset=0 after 2 beats, release; then issue a new read.
  - Required: io_busy=0 after reset, first 2 words written, the new read is accepted normally.
